alu_issue: RTL and testbench

Operand-issue and writeback stage that sits directly upstream of the combinational ALU. It holds a 32 x 32 general register file and accepts three-address commands over a valid/ready handshake. For each command it reads and drives the ALU operands for one cycle, then captures the ALU result, writes it back to the register file and presents it on a backpressured result port.

---
 rtl/alu_issue.sv | 138 +++++++++++++
 tb/tb_alu_issue.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Operand-issue/writeback stage in front of a combinational ALU: 2^AW x WIDTH register file, three-address commands.
// Latency: command accepted at edge N drives the ALU during N..N+1; result and register write land at edge N+1.
// Backpressure: holds at most two commands (EX and RES); cmd_ready drops only when both are full and res_ready is low.
module alu_issue #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rs,
    input  logic [AW-1:0]    cmd_rt,
    input  logic [AW-1:0]    cmd_rd,
    input  logic             cmd_imm_sel,
    input  logic [WIDTH-1:0] cmd_imm,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_c,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [AW-1:0]    res_rd
);

    localparam int NREG = 1 << AW;

    // EX stage: operands and opcode currently presented to the ALU
    logic             ex_valid;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [2:0]       ex_op;
    logic [AW-1:0]    ex_rd;

    // Architectural register file; entry 0 is never written so it stays zero
    logic [WIDTH-1:0] rf [NREG];

    logic             res_free;
    logic             ex_adv;
    logic             accept;
    logic             fwd_ok;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] b_val;

    // Stall network: EX retires when RES is empty or being drained; a command enters when EX is empty or retiring
    always_comb begin
        res_free  = !res_valid || res_ready;
        ex_adv    = ex_valid && res_free;
        cmd_ready = !ex_valid || ex_adv;
        accept    = cmd_valid && cmd_ready;
        // The retiring EX result is written at this same edge, so a reader must take it from the ALU output
        fwd_ok    = ex_adv && (ex_rd != '0);
    end

    // Source A read with zero-register and bypass from the retiring result
    always_comb begin
        rs_val = rf[cmd_rs];
        if (cmd_rs == '0) begin
            rs_val = '0;
        end else if (fwd_ok && (cmd_rs == ex_rd)) begin
            rs_val = alu_c;
        end
    end

    // Source B read with the same rules, then the immediate select
    always_comb begin
        rt_val = rf[cmd_rt];
        if (cmd_rt == '0) begin
            rt_val = '0;
        end else if (fwd_ok && (cmd_rt == ex_rd)) begin
            rt_val = alu_c;
        end
        b_val = cmd_imm_sel ? cmd_imm : rt_val;
    end

    // EX registers: load a new command on accept, empty when retiring with nothing behind it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_op    <= '0;
            ex_rd    <= '0;
        end else begin
            if (accept) begin
                ex_valid <= 1'b1;
                ex_a     <= rs_val;
                ex_b     <= b_val;
                ex_op    <= cmd_op;
                ex_rd    <= cmd_rd;
            end else if (ex_adv) begin
                ex_valid <= 1'b0;
            end
        end
    end

    // RES registers: capture the ALU result on retire; on a plain drain only the valid flag clears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
        end else begin
            if (ex_adv) begin
                res_valid <= 1'b1;
                res_data  <= alu_c;
                res_rd    <= ex_rd;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    // Register-file writeback of the retiring result; writes to r0 are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (fwd_ok) begin
                rf[ex_rd] <= alu_c;
            end
        end
    end

    // ALU is driven purely from registered EX state
    assign alu_a  = ex_a;
    assign alu_b  = ex_b;
    assign alu_op = ex_op;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: an in-order transaction model predicts every cycle's outputs.
// The bench also plays the external combinational ALU.
// Directed scenarios pin the model with literal results; a randomized phase follows.
module tb_alu_issue;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AW-1:0]    cmd_rs;
    logic [AW-1:0]    cmd_rt;
    logic [AW-1:0]    cmd_rd;
    logic             cmd_imm_sel;
    logic [WIDTH-1:0] cmd_imm;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_c;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [AW-1:0]    res_rd;

    always #5 clk = ~clk;

    alu_issue #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rs      (cmd_rs),
        .cmd_rt      (cmd_rt),
        .cmd_rd      (cmd_rd),
        .cmd_imm_sel (cmd_imm_sel),
        .cmd_imm     (cmd_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_c       (alu_c),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a >> b[4:0];
            3'd5:    return 32'($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    // External ALU
    always_comb alu_c = alu_f(alu_op, alu_a, alu_b);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  op;
        logic [4:0]  rd;
    } ent_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } obs_t;

    int          vectors = 0;
    int          miscompares = 0;
    ent_t        exp_q[$];     // commands in flight, oldest first
    logic [31:0] mreg[32];     // architectural register state in program order
    bit          ex_only;      // single in-flight command was accepted at the last edge
    obs_t        obs_q[$];     // results the DUT handed over, for literal checks
    logic        last_ready;
    logic        last_rvalid;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // One clock cycle: drive inputs, compare all outputs against the model, then advance the model
    task automatic step(input bit v, input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input bit isel, input logic [31:0] imm, input bit rr,
                        output bit acc);
        bit   exp_ready;
        bit   exp_rv;
        bit   cons;
        int   n;
        ent_t e;
        @(negedge clk);
        cmd_valid   = v;
        cmd_op      = op;
        cmd_rs      = rs;
        cmd_rt      = rt;
        cmd_rd      = rd;
        cmd_imm_sel = isel;
        cmd_imm     = imm;
        res_ready   = rr;
        #1;
        n         = exp_q.size();
        exp_ready = (n < 2) || rr;
        exp_rv    = (n >= 2) || (n == 1 && !ex_only);
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("res_data", res_data, exp_q[0].res);
            chk("res_rd", 32'(res_rd), 32'(exp_q[0].rd));
        end
        if (n == 2 || (n == 1 && ex_only)) begin
            e = exp_q[n-1];
            chk("alu_a", alu_a, e.a);
            chk("alu_b", alu_b, e.b);
            chk("alu_op", 32'(alu_op), 32'(e.op));
        end
        last_ready  = cmd_ready;
        last_rvalid = res_valid;
        acc  = v && exp_ready;
        cons = exp_rv && rr;
        if (cons) obs_q.push_back({res_rd, res_data});
        @(posedge clk);
        if (cons) e = exp_q.pop_front();
        if (acc) begin
            e.a   = (rs == 5'd0) ? 32'd0 : mreg[rs];
            e.b   = isel ? imm : ((rt == 5'd0) ? 32'd0 : mreg[rt]);
            e.op  = op;
            e.rd  = rd;
            e.res = alu_f(op, e.a, e.b);
            exp_q.push_back(e);
            if (rd != 5'd0) mreg[rd] = e.res;
        end
        ex_only = acc && (exp_q.size() == 1);
    endtask

    // Offer a command until accepted, with a bounded number of attempts
    task automatic issue(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input bit isel, input logic [31:0] imm, input bit rr);
        bit a;
        int t;
        t = 0;
        a = 1'b0;
        while (!a && t < 20) begin
            step(1'b1, op, rs, rt, rd, isel, imm, rr, a);
            t++;
        end
        if (!a) fail_now("issue_timeout");
    endtask

    task automatic idle(input int k, input bit rr);
        bit a;
        repeat (k) step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, rr, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_rd", 32'(res_rd), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        ex_only = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    // Check the i-th handed-over result against literal values
    task automatic lit(input string name, input int i, input logic [4:0] rd, input logic [31:0] data);
        if (i < obs_q.size()) begin
            chk({name, "_data"}, obs_q[i].data, data);
            chk({name, "_rd"}, 32'(obs_q[i].rd), 32'(rd));
        end else begin
            fail_now({name, "_missing"});
        end
    endtask

    initial begin
        bit   a;
        int   k;
        int   t;
        logic rdy[4];
        logic rv3, rv4, rv5, rv6, rdy3, rdy4;

        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_rs      = '0;
        cmd_rt      = '0;
        cmd_rd      = '0;
        cmd_imm_sel = 1'b0;
        cmd_imm     = '0;
        res_ready   = 1'b0;
        ex_only     = 1'b0;
        do_reset();

        // Reset mid-stream: r1 written before reset must read back as 0
        issue(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'h55, 1'b0);
        issue(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'h66, 1'b0);
        do_reset();
        obs_q.delete();
        issue(3'd0, 5'd1, 5'd0, 5'd5, 1'b1, 32'd0, 1'b1);
        idle(3, 1'b1);
        chk("rst_count", 32'(obs_q.size()), 32'd1);
        lit("rst_read", 0, 5'd5, 32'd0);

        // Back-to-back with forwarding
        obs_q.delete();
        issue(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5, 1'b1);
        issue(3'd0, 5'd0, 5'd0, 5'd2, 1'b1, 32'd3, 1'b1);
        issue(3'd1, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0, 1'b1);
        idle(4, 1'b1);
        chk("b2b_count", 32'(obs_q.size()), 32'd3);
        lit("b2b0", 0, 5'd1, 32'd5);
        lit("b2b1", 1, 5'd2, 32'd3);
        lit("b2b2", 2, 5'd3, 32'd2);

        // Backpressure: four commands against a stalled consumer
        obs_q.delete();
        k = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'd0, 5'd0, 5'd0, 5'(4 + k), 1'b1, 32'(10 + k), 1'b0, a);
            rdy[i] = last_ready;
            if (a) k++;
        end
        chk("bp_accepts", 32'(k), 32'd2);
        chk("bp_rdy0", 32'(rdy[0]), 32'd1);
        chk("bp_rdy1", 32'(rdy[1]), 32'd1);
        chk("bp_rdy2", 32'(rdy[2]), 32'd0);
        chk("bp_rdy3", 32'(rdy[3]), 32'd0);
        t = 0;
        while (k < 4 && t < 20) begin
            step(1'b1, 3'd0, 5'd0, 5'd0, 5'(4 + k), 1'b1, 32'(10 + k), 1'b1, a);
            if (a) k++;
            t++;
        end
        idle(4, 1'b1);
        chk("bp_count", 32'(obs_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) lit("bp", i, 5'(4 + i), 32'(10 + i));

        // Zero register: result still reported, but r0 stays zero even back-to-back
        obs_q.delete();
        issue(3'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'd7, 1'b1);
        issue(3'd3, 5'd0, 5'd0, 5'd8, 1'b0, 32'd0, 1'b1);
        idle(3, 1'b1);
        lit("zero_wr", 0, 5'd0, 32'd7);
        lit("zero_rd", 1, 5'd8, 32'd0);

        // Shifts and an undefined opcode
        obs_q.delete();
        issue(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'h8000_0000, 1'b1);
        issue(3'd5, 5'd1, 5'd0, 5'd2, 1'b1, 32'd4, 1'b1);
        issue(3'd4, 5'd1, 5'd0, 5'd3, 1'b1, 32'd4, 1'b1);
        issue(3'd6, 5'd1, 5'd0, 5'd4, 1'b1, 32'd4, 1'b1);
        idle(4, 1'b1);
        lit("sh_set", 0, 5'd1, 32'h8000_0000);
        lit("sh_sra", 1, 5'd2, 32'hF800_0000);
        lit("sh_srl", 2, 5'd3, 32'h0800_0000);
        lit("sh_op6", 3, 5'd4, 32'd0);

        // Drain and fill on the same edge
        obs_q.delete();
        step(1'b1, 3'd0, 5'd0, 5'd0, 5'd9, 1'b1, 32'd21, 1'b0, a);
        step(1'b1, 3'd0, 5'd0, 5'd0, 5'd10, 1'b1, 32'd22, 1'b0, a);
        step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, a);
        rv3 = last_rvalid; rdy3 = last_ready;
        step(1'b1, 3'd0, 5'd0, 5'd0, 5'd11, 1'b1, 32'd23, 1'b1, a);
        rv4 = last_rvalid; rdy4 = last_ready;
        step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, a);
        rv5 = last_rvalid;
        step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, a);
        rv6 = last_rvalid;
        idle(2, 1'b1);
        chk("df_rdy_stalled", 32'(rdy3), 32'd0);
        chk("df_rdy_release", 32'(rdy4), 32'd1);
        chk("df_rv3", 32'(rv3), 32'd1);
        chk("df_rv4", 32'(rv4), 32'd1);
        chk("df_rv5", 32'(rv5), 32'd1);
        chk("df_rv6", 32'(rv6), 32'd1);
        chk("df_count", 32'(obs_q.size()), 32'd3);
        lit("df0", 0, 5'd9, 32'd21);
        lit("df1", 1, 5'd10, 32'd22);
        lit("df2", 2, 5'd11, 32'd23);

        // Randomized traffic with occasional resets; small register range stresses forwarding
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 9) < 7), a);
            end
        end
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
